// File: rtl/dec_sb_pkg.sv
// dec_sb_pkg: shared types and constants for the decode-stage scoreboard.
//   stage_t    - one tracked pipeline entry {vld, wen, rd, is_load}
//   SEL_RF     - forwarding select value meaning "use the register file"
//   NOP_ENTRY  - invalid bubble entry shifted into stage 0 when nothing issues
//   RD_W_MAX   - storage width of the rd field; ADDR_W must not exceed it
package dec_sb_pkg;

  localparam int RD_W_MAX = 8;
  localparam int SEL_RF   = 0;

  typedef struct packed {
    logic                vld;
    logic                wen;
    logic [RD_W_MAX-1:0] rd;
    logic                is_load;
  } stage_t;

  localparam stage_t NOP_ENTRY = '{vld: 1'b0, wen: 1'b0, rd: '0, is_load: 1'b0};

endpackage

// File: rtl/dec_sb_match.sv
// dec_sb_match: compares one source operand against every tracked stage and
// reports the youngest (lowest index) stage that will write that register.
// Ports:
//   addr    in   operand register address
//   used    in   instruction actually reads this operand
//   stages  in   tracked stage entries, index 0 = youngest (EX)
//   hit     out  some stage matches
//   idx     out  index of the youngest matching stage (0 when no hit)
//   is_load out  youngest matching stage holds a load
module dec_sb_match
  import dec_sb_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 3,
  parameter int IDX_W  = $clog2(DEPTH)
) (
  input  logic [ADDR_W-1:0]      addr,
  input  logic                   used,
  input  stage_t [DEPTH-1:0]     stages,
  output logic                   hit,
  output logic [IDX_W-1:0]       idx,
  output logic                   is_load
);

  logic [RD_W_MAX-1:0] addr_ext;

  assign addr_ext = RD_W_MAX'(addr);

  // Scan from the oldest stage to the youngest so that the last match
  // written is the youngest one; x0 never matches.
  always_comb begin
    hit     = 1'b0;
    idx     = '0;
    is_load = 1'b0;
    if (used && (addr != '0)) begin
      for (int k = DEPTH - 1; k >= 0; k--) begin
        if (stages[k].vld && stages[k].wen && (stages[k].rd == addr_ext)) begin
          hit     = 1'b1;
          idx     = IDX_W'(k);
          is_load = stages[k].is_load;
        end
      end
    end
  end

endmodule

// File: rtl/dec_sb.sv
// dec_sb: decode-stage scoreboard and hazard unit. Tracks the last DEPTH
// issued instructions in a shift register, produces per-operand forwarding
// selects and the load-use / counter stall, and keeps a per-register count
// of writers still in flight.
// Optional feature macro: DEC_SB_LONGLAT_EN - when defined, a used operand
// whose register has an in-flight writer that is no longer in any tracked
// stage also stalls decode until its writeback arrives.
// Ports:
//   i_clk, i_rst                clock, asynchronous active-high reset
//   i_dec_vld                   decode holds a valid instruction
//   i_rs1_raddr, i_rs1_used     source 1 address / read enable
//   i_rs2_raddr, i_rs2_used     source 2 address / read enable
//   i_rd_waddr, i_rd_wen        destination address / write enable
//   i_is_load                   decode instruction is a load
//   i_flush                     decode instruction squashed
//   i_freeze                    all tracked stages hold
//   i_wb_wen, i_wb_waddr        register file write port
//   o_issue                     decode instruction enters stage 0
//   o_stall                     hold IF/ID, bubble into stage 0
//   o_fwd_sel1, o_fwd_sel2      0 = register file, k = result of stage k-1
//   o_busy_vec                  register has an in-flight writer
module dec_sb
  import dec_sb_pkg::*;
#(
  parameter int ADDR_W     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 1,
  parameter int SEL_W      = $clog2(DEPTH + 1),
  parameter int CNT_W      = $clog2(DEPTH + 2)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_dec_vld,
  input  logic [ADDR_W-1:0]      i_rs1_raddr,
  input  logic [ADDR_W-1:0]      i_rs2_raddr,
  input  logic                   i_rs1_used,
  input  logic                   i_rs2_used,
  input  logic [ADDR_W-1:0]      i_rd_waddr,
  input  logic                   i_rd_wen,
  input  logic                   i_is_load,
  input  logic                   i_flush,
  input  logic                   i_freeze,
  input  logic                   i_wb_wen,
  input  logic [ADDR_W-1:0]      i_wb_waddr,
  output logic                   o_issue,
  output logic                   o_stall,
  output logic [SEL_W-1:0]       o_fwd_sel1,
  output logic [SEL_W-1:0]       o_fwd_sel2,
  output logic [2**ADDR_W-1:0]   o_busy_vec
);

  localparam int               NUM_REGS = 2 ** ADDR_W;
  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W-1:0] LOAD_IDX = IDX_W'(LOAD_STAGE);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  stage_t [DEPTH-1:0]                stg;
  stage_t                            dec_entry;
  logic                              hit1, hit2, ld1, ld2;
  logic [IDX_W-1:0]                  idx1, idx2;
  logic                              load_use, sat_stall, long_stall, stall_raw;
  logic [NUM_REGS-1:0][CNT_W-1:0]    cnt;

  dec_sb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_match1 (
    .addr    (i_rs1_raddr),
    .used    (i_rs1_used),
    .stages  (stg),
    .hit     (hit1),
    .idx     (idx1),
    .is_load (ld1)
  );

  dec_sb_match #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .IDX_W(IDX_W)) u_match2 (
    .addr    (i_rs2_raddr),
    .used    (i_rs2_used),
    .stages  (stg),
    .hit     (hit2),
    .idx     (idx2),
    .is_load (ld2)
  );

  // A load only has data from LOAD_STAGE onwards; a younger matching load
  // cannot be forwarded yet.
  assign load_use = (hit1 && ld1 && (idx1 < LOAD_IDX)) ||
                    (hit2 && ld2 && (idx2 < LOAD_IDX));

  // Issuing another writer to a saturated counter would wrap it.
  assign sat_stall = i_rd_wen && (i_rd_waddr != '0) && (cnt[i_rd_waddr] == CNT_MAX);

`ifdef DEC_SB_LONGLAT_EN
  logic pend1, pend2;

  // A writer is still outstanding unless this cycle's writeback retires the
  // last one, which lets the stall drop in the same cycle as the write.
  always_comb begin
    pend1 = (cnt[i_rs1_raddr] != '0) &&
            !((cnt[i_rs1_raddr] == CNT_W'(1)) && i_wb_wen && (i_wb_waddr == i_rs1_raddr));
    pend2 = (cnt[i_rs2_raddr] != '0) &&
            !((cnt[i_rs2_raddr] == CNT_W'(1)) && i_wb_wen && (i_wb_waddr == i_rs2_raddr));
    long_stall = (i_rs1_used && (i_rs1_raddr != '0) && !hit1 && pend1) ||
                 (i_rs2_used && (i_rs2_raddr != '0) && !hit2 && pend2);
  end
`else
  assign long_stall = 1'b0;
`endif

  assign stall_raw = load_use || sat_stall || long_stall;
  assign o_stall   = i_dec_vld && !i_rst && stall_raw;
  assign o_issue   = i_dec_vld && !i_rst && !stall_raw && !i_flush && !i_freeze;

  assign o_fwd_sel1 = (hit1 && !i_rst) ? (SEL_W'(idx1) + SEL_W'(1)) : SEL_W'(SEL_RF);
  assign o_fwd_sel2 = (hit2 && !i_rst) ? (SEL_W'(idx2) + SEL_W'(1)) : SEL_W'(SEL_RF);

  always_comb begin
    dec_entry         = NOP_ENTRY;
    dec_entry.vld     = 1'b1;
    dec_entry.wen     = i_rd_wen;
    dec_entry.rd      = RD_W_MAX'(i_rd_waddr);
    dec_entry.is_load = i_is_load;
  end

  // Stage shift register; a freeze holds every stage, otherwise a bubble
  // enters stage 0 whenever nothing issues (stall, flush or idle decode).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int k = 0; k < DEPTH; k++) stg[k] <= NOP_ENTRY;
    end else if (!i_freeze) begin
      stg[0] <= o_issue ? dec_entry : NOP_ENTRY;
      for (int k = 1; k < DEPTH; k++) stg[k] <= stg[k-1];
    end
  end

  assign cnt[0]        = '0;
  assign o_busy_vec[0] = 1'b0;

  // Per-register in-flight writer counters; x0 has none.
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    logic             inc, dec;
    logic [CNT_W-1:0] c;

    assign inc = o_issue && i_rd_wen && (i_rd_waddr == ADDR_W'(r));
    assign dec = i_wb_wen && (i_wb_waddr == ADDR_W'(r));

    always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
        c <= '0;
      end else if (inc && !dec) begin
        c <= c + CNT_W'(1);
      end else if (dec && !inc) begin
        c <= c - CNT_W'(1);
      end
    end

    assign cnt[r]        = c;
    assign o_busy_vec[r] = (c != '0);
  end

  // A writeback with no recorded writer means the pipeline lost track.
  a_no_underflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(i_wb_wen && (i_wb_waddr != '0) && (cnt[i_wb_waddr] == '0)));

endmodule

// File: doc/dec_sb.md
Name: dec_sb

Overview:
Parametrised scoreboard and hazard unit for the decode stage. It replaces the fixed two-stage load-use check with a shift-register model of the last DEPTH issued instructions. Per source operand it produces the forwarding select and the stall decision, and it tracks the writers still in flight. It sits beside the register file in decode; the forwarding mux consumes its selects, and fetch and decode consume its stall.

Parameters:
ADDR_W, 5, register address width; NUM_REGS = 2**ADDR_W.
DEPTH, 3, tracked stages after decode (stage 0 = EX, 1 = MEM, 2 = WB); minimum 2.
LOAD_STAGE, 1, first stage index whose output carries load data; 1 to DEPTH-1.
SEL_W, $clog2(DEPTH+1), width of a forwarding select.
CNT_W, $clog2(DEPTH+2), width of a per-register in-flight counter.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_dec_vld  in  1  decode holds a valid instruction
i_rs1_raddr  in  ADDR_W  source 1 address
i_rs2_raddr  in  ADDR_W  source 2 address
i_rs1_used  in  1  instruction reads rs1
i_rs2_used  in  1  instruction reads rs2
i_rd_waddr  in  ADDR_W  destination address
i_rd_wen  in  1  instruction writes rd
i_is_load  in  1  instruction is a load
i_flush  in  1  decode instruction is squashed (branch/jump redirect)
i_freeze  in  1  data-cache busy: all tracked stages hold
i_wb_wen  in  1  register file write this cycle
i_wb_waddr  in  ADDR_W  register file write address
o_issue  out  1  decode instruction enters stage 0 this cycle
o_stall  out  1  hold IF/ID; a bubble enters stage 0
o_fwd_sel1  out  SEL_W  0 = register file, k = result of stage k-1
o_fwd_sel2  out  SEL_W  same encoding for rs2
o_busy_vec  out  NUM_REGS  bit r set while register r has an in-flight writer

Behaviour:
- Reset is asynchronous, active-high. Every stage entry becomes invalid, all counters clear, o_busy_vec = 0. Selects read 0 and o_stall reads 0 while reset is asserted.
- Stage entry contents: {vld, wen, rd, is_load}.
- A match on operand X at stage k requires all of:
  - X is used and its address is not 0;
  - the stage-k entry is valid with wen set;
  - the stage-k rd equals the operand address.
- o_fwd_sel is the youngest (lowest k) match plus 1, or 0 when nothing matches. Older matches are ignored.
- Load-use hazard: the youngest match is a load and k < LOAD_STAGE.
- o_stall = i_dec_vld & (load-use hazard on either operand, or counter-saturation stall). It is combinational.
- o_issue = i_dec_vld & !o_stall & !i_flush & !i_freeze.
- Shift rule, each clock edge:
  - if i_freeze is high, all stages hold;
  - otherwise stage k+1 takes stage k, and stage 0 takes the decode entry when o_issue is high, else an invalid bubble.
- i_flush never touches tracked stages. A flush together with a stall still inserts a bubble.
- Counters (one per register, x0 excluded):
  - increment on o_issue & i_rd_wen & rd != 0;
  - decrement on i_wb_wen & waddr != 0;
  - a simultaneous increment and decrement on the same register leaves it unchanged.
- Counter underflow never happens in legal use. The verification assertion is: decrement when counter == 0.
- Counter saturation: if the rd counter equals 2**CNT_W-1, o_stall asserts and issue waits.
- o_busy_vec[r] = (counter r != 0); bit 0 is always 0.
- Reset asserted mid-operation discards every in-flight entry; no writeback-clear is required afterwards.

Optional Feature:
Macro: DEC_SB_LONGLAT_EN.
- Defined: a used operand whose counter is nonzero but which has no stage match also raises o_stall. This covers writers stretched beyond DEPTH by cache misses; the stall clears on the matching i_wb_wen.
- Undefined: the counter-based stall is absent, and the register-file write bypass is relied on for writers past the last stage.
- o_busy_vec and the counters exist in both builds.

Decomposition:
- Package dec_sb_pkg: the stage-entry struct type, the encoding constant SEL_RF = 0, and the NOP entry constant.
- One sub-module, dec_sb_match: compares one operand against all stages and returns the youngest-match index and its is_load flag. It is instantiated twice, once per operand.

Test Plan:
- Back-to-back ALU: `add x5` then `add x6,x5,x5` → sel1 = sel2 = 1, o_stall = 0, o_issue = 1.
- Load-use: `lw x7` then `add x8,x7,x0` → o_stall = 1 for one cycle, then issue with sel1 = 2 and sel2 = 0.
- Youngest wins: `x9` written in stage 0 and stage 2 → sel = 1. With rs = x0 in the same pattern → sel = 0.
- Freeze: hold i_freeze for 4 cycles with a load in stage 0 → stages unchanged, o_issue = 0; the stall persists until release.
- Flush plus stall in the same cycle → bubble into stage 0, o_issue = 0, counters unchanged.
- DEC_SB_LONGLAT_EN defined: `x10` counter = 1 with no stage match and rs1 = x10 → o_stall = 1. i_wb_wen to x10 → o_stall = 0 in the same cycle, and o_busy_vec[10] clears on the next edge.
